alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared combinational ALU. Each requester submits an operand/opcode triple over a valid/ready handshake. The block grants one requester, drives the latched operands onto the shared ALU, and captures the result one cycle later. It then returns the result to the granted requester over a second valid/ready handshake. It sits between the input front-ends (switch/button capture, UART command decoder) and the single `alu` instance, replacing direct operand registers when more than one source needs the ALU.

---
 rtl/alu_arb_pkg.sv | 16 +
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter/sequencer and the alu datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int BITS_DATA = 8;
  localparam int BITS_OP   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/ALU/response bundle between the front-ends, the arbiter and the shared alu.
// Latency: n/a (wires only).
// Backpressure: req side valid/ready, rsp side valid/ready; slave = arbiter view.
interface alu_arbiter_if #(
  parameter int BITS_DATA = alu_arb_pkg::BITS_DATA,
  parameter int BITS_OP   = alu_arb_pkg::BITS_OP
);

  logic        [1:0]             i_req_valid;
  logic        [1:0]             o_req_ready;
  logic        [2*BITS_DATA-1:0] i_req_a;
  logic        [2*BITS_DATA-1:0] i_req_b;
  logic        [2*BITS_OP-1:0]   i_req_op;
  logic signed [BITS_DATA-1:0]   o_alu_a;
  logic signed [BITS_DATA-1:0]   o_alu_b;
  logic        [BITS_OP-1:0]     o_alu_op;
  logic        [BITS_DATA-1:0]   i_alu_result;
  logic        [1:0]             o_rsp_valid;
  logic        [1:0]             i_rsp_ready;
  logic        [BITS_DATA-1:0]   o_rsp_result;
  logic                          o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_op, i_alu_result, i_rsp_ready,
    output o_req_ready, o_alu_a, o_alu_b, o_alu_op, o_rsp_valid, o_rsp_result, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_op, i_alu_result, i_rsp_ready,
    input  o_req_ready, o_alu_a, o_alu_b, o_alu_op, o_rsp_valid, o_rsp_result, o_busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way grant selection; ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties).
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is used.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant,
  output logic       o_idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Pointer is meaningless with fixed priority.
  wire w_unused_last = i_last;

  assign o_idx = ~i_req[0];
`else
  // A tie goes to the requester that did not win last; a lone request always wins.
  assign o_idx = (i_req == 2'b11) ? ~i_last : ~i_req[0];
`endif

  assign o_grant = (i_req == 2'b00) ? 2'b00 : (o_idx ? 2'b10 : 2'b01);

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto the shared alu and returns the captured result (ALU_ARB_FIXED_PRIO_EN: fixed priority).
// Latency: accept at edge N, rsp_valid from cycle N+2; minimum issue interval 3 cycles.
// Backpressure: one transaction in flight; req_ready low in EXEC/RESP, RESP holds until rsp_ready.
module alu_arbiter
  import alu_arb_pkg::*;
(
  input  logic         clk,
  input  logic         i_reset,
  alu_arbiter_if.slave bus
);

  state_t                 r_state;
  state_t                 w_next;
  logic [BITS_DATA-1:0]   r_a;
  logic [BITS_DATA-1:0]   r_b;
  logic [BITS_DATA-1:0]   r_result;
  logic [BITS_OP-1:0]     r_op;
  logic                   r_grant;
  logic                   w_last;
  logic                   w_idx;
  logic                   w_any;
  logic                   w_accept;
  logic [NUM_REQ-1:0]     w_onehot;
  logic [NUM_REQ-1:0]     w_req_ready;
  logic [NUM_REQ-1:0]     w_rsp_valid;
  logic [BITS_DATA-1:0]   w_sel_a;
  logic [BITS_DATA-1:0]   w_sel_b;
  logic [BITS_OP-1:0]     w_sel_op;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_last = 1'b0;
`else
  logic r_last;

  assign w_last = r_last;

  // Pointer advances only when the response handshake completes, so an aborted op leaves it untouched.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_last <= 1'b1;
    end else if (r_state == ST_RESP && bus.i_rsp_ready[r_grant]) begin
      r_last <= r_grant;
    end
  end
`endif

  rr_arbiter2 u_arb (
    .i_req   (bus.i_req_valid),
    .i_last  (w_last),
    .o_grant (w_onehot),
    .o_idx   (w_idx)
  );

  assign w_any    = |bus.i_req_valid;
  assign w_accept = (r_state == ST_IDLE) && w_any;

  assign w_sel_a  = w_idx ? bus.i_req_a[BITS_DATA +: BITS_DATA] : bus.i_req_a[0 +: BITS_DATA];
  assign w_sel_b  = w_idx ? bus.i_req_b[BITS_DATA +: BITS_DATA] : bus.i_req_b[0 +: BITS_DATA];
  assign w_sel_op = w_idx ? bus.i_req_op[BITS_OP +: BITS_OP]    : bus.i_req_op[0 +: BITS_OP];

  // State register.
  always_ff @(posedge clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next state and handshake strobes.
  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    w_rsp_valid = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_req_ready = w_onehot;
          w_next      = ST_EXEC;
        end
      end
      ST_EXEC: w_next = ST_RESP;
      ST_RESP: begin
        w_rsp_valid[r_grant] = 1'b1;
        if (bus.i_rsp_ready[r_grant]) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand/grant latch on accept, result capture in EXEC; everything holds otherwise.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_grant  <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= w_sel_a;
        r_b     <= w_sel_b;
        r_op    <= w_sel_op;
        r_grant <= w_idx;
      end
      if (r_state == ST_EXEC) r_result <= bus.i_alu_result;
    end
  end

  // Reset wins over any handshake presented in the same cycle.
  assign bus.o_req_ready  = i_reset ? '0 : w_req_ready;
  assign bus.o_rsp_valid  = i_reset ? '0 : w_rsp_valid;
  assign bus.o_rsp_result = r_result;
  assign bus.o_alu_a      = r_a;
  assign bus.o_alu_b      = r_b;
  assign bus.o_alu_op     = r_op;
  assign bus.o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, corner sequences, randomized traffic.
// Latency: checks accept -> EXEC -> RESP timing cycle by cycle.
// Backpressure: exercises response stalls and reset aborts.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;

  logic clk = 1'b0;
  logic i_reset;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_last;

  typedef struct {
    logic [1:0] v;
    logic [7:0] a0, b0;
    logic [5:0] op0;
    logic [7:0] a1, b1;
    logic [5:0] op1;
    int         g;
    logic [7:0] r;
    int         stall;
  } vec_t;

  vec_t tbl [6];

  // Behavioural alu: what the shared alu returns for a given operand/opcode triple.
  function automatic logic [7:0] ref_alu(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb bus.i_alu_result = ref_alu(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  // Expected winner from the arbitration rules.
  function automatic int winner(logic [1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v[0] ? 0 : 1;
`else
    if (v == 2'b11) return 1 - m_last;
    return v[0] ? 0 : 1;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_req_ready"}, {30'b0, bus.o_req_ready}, 32'h0);
    check({tag, "_rsp_valid"}, {30'b0, bus.o_rsp_valid}, 32'h0);
    check({tag, "_busy"},      {31'b0, bus.o_busy}, 32'h0);
    check({tag, "_alu_a"},     {24'b0, bus.o_alu_a}, 32'h0);
    check({tag, "_alu_b"},     {24'b0, bus.o_alu_b}, 32'h0);
    check({tag, "_alu_op"},    {26'b0, bus.o_alu_op}, 32'h0);
    check({tag, "_rsp_res"},   {24'b0, bus.o_rsp_result}, 32'h0);
  endtask

  // One full transaction: accept, EXEC, RESP with optional stall, completion.
  task automatic do_txn(logic [1:0] v, logic [7:0] a0, logic [7:0] b0, logic [5:0] op0,
                        logic [7:0] a1, logic [7:0] b1, logic [5:0] op1,
                        int g, logic [7:0] r, int stall);
    logic [1:0] oh;
    logic [7:0] ea, eb;
    logic [5:0] eop;
    oh  = (g == 1) ? 2'b10 : 2'b01;
    ea  = (g == 1) ? a1 : a0;
    eb  = (g == 1) ? b1 : b0;
    eop = (g == 1) ? op1 : op0;
    @(negedge clk);
    bus.i_req_valid = v;
    bus.i_req_a     = {a1, a0};
    bus.i_req_b     = {b1, b0};
    bus.i_req_op    = {op1, op0};
    bus.i_rsp_ready = 2'b00;
    #1;
    check("req_ready", {30'b0, bus.o_req_ready}, {30'b0, oh});
    check("busy_idle", {31'b0, bus.o_busy}, 32'h0);
    @(negedge clk);
    bus.i_req_valid = 2'b00;
    #1;
    check("busy_exec",   {31'b0, bus.o_busy}, 32'h1);
    check("rsp_vld_exec", {30'b0, bus.o_rsp_valid}, 32'h0);
    check("alu_a",  {24'b0, bus.o_alu_a},  {24'b0, ea});
    check("alu_b",  {24'b0, bus.o_alu_b},  {24'b0, eb});
    check("alu_op", {26'b0, bus.o_alu_op}, {26'b0, eop});
    @(negedge clk);
    #1;
    check("rsp_valid",  {30'b0, bus.o_rsp_valid}, {30'b0, oh});
    check("rsp_result", {24'b0, bus.o_rsp_result}, {24'b0, r});
    for (int i = 0; i < stall; i++) begin
      bus.i_req_valid = 2'b11;
      bus.i_rsp_ready = ~oh;
      @(negedge clk);
      #1;
      check("stall_rsp_valid", {30'b0, bus.o_rsp_valid}, {30'b0, oh});
      check("stall_result",    {24'b0, bus.o_rsp_result}, {24'b0, r});
      check("stall_req_ready", {30'b0, bus.o_req_ready}, 32'h0);
      check("stall_alu_a",     {24'b0, bus.o_alu_a}, {24'b0, ea});
    end
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = oh;
    @(negedge clk);
    #1;
    check("done_rsp_valid", {30'b0, bus.o_rsp_valid}, 32'h0);
    check("done_busy",      {31'b0, bus.o_busy}, 32'h0);
    check("done_result",    {24'b0, bus.o_rsp_result}, {24'b0, r});
    check("done_alu_a",     {24'b0, bus.o_alu_a}, {24'b0, ea});
    bus.i_rsp_ready = 2'b00;
    m_last = g;
  endtask

  initial begin
    int         g;
    logic [7:0] r;
    logic [1:0] v;
    logic [7:0] a0, b0, a1, b1;
    logic [5:0] op0, op1;
    logic [5:0] ops [5];

    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR; ops[4] = 6'b000111;

    // Round-robin expectations, pointer starting at 1.
    tbl[0] = '{2'b11, 8'd10,  8'd20, OP_ADD, 8'd9,   8'd4,  OP_SUB, 0, 8'd30,  0};
    tbl[1] = '{2'b11, 8'd10,  8'd20, OP_ADD, 8'd9,   8'd4,  OP_SUB, 1, 8'd5,   2};
    tbl[2] = '{2'b01, 8'd5,   8'd3,  OP_ADD, 8'd0,   8'd0,  OP_ADD, 0, 8'd8,   0};
    tbl[3] = '{2'b11, 8'd100, 8'd27, OP_ADD, 8'h80,  8'd1,  OP_ADD, 1, 8'h81,  1};
    tbl[4] = '{2'b11, 8'd100, 8'd27, OP_ADD, 8'h80,  8'd1,  OP_ADD, 0, 8'd127, 0};
    tbl[5] = '{2'b10, 8'd0,   8'd0,  OP_ADD, 8'd3,   8'd5,  OP_SUB, 1, 8'hFE,  0};

    // Reset with both requests asserted: ready must stay low.
    i_reset         = 1'b1;
    bus.i_req_valid = 2'b11;
    bus.i_req_a     = 16'h1234;
    bus.i_req_b     = 16'h5678;
    bus.i_req_op    = {OP_ADD, OP_ADD};
    bus.i_rsp_ready = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    i_reset         = 1'b0;
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 2'b00;
    m_last          = 1;

    // Vector table.
    for (int k = 0; k < 6; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = winner(tbl[k].v);
      r = g ? ref_alu(tbl[k].a1, tbl[k].b1, tbl[k].op1) : ref_alu(tbl[k].a0, tbl[k].b0, tbl[k].op0);
`else
      g = tbl[k].g;
      r = tbl[k].r;
`endif
      do_txn(tbl[k].v, tbl[k].a0, tbl[k].b0, tbl[k].op0, tbl[k].a1, tbl[k].b1, tbl[k].op1,
             g, r, tbl[k].stall);
    end

    // Long response stall on requester 1 while requester 0 keeps asking.
    do_txn(2'b10, 8'd1, 8'd1, OP_ADD, 8'd50, 8'd7, OP_SUB, winner(2'b10), 8'd43, 10);

    // Leave the pointer at 0, then abort a transaction in EXEC.
    do_txn(2'b01, 8'd1, 8'd2, OP_ADD, 8'd0, 8'd0, OP_ADD, 0, 8'd3, 0);
    @(negedge clk);
    bus.i_req_valid = 2'b01;
    bus.i_req_a     = {8'd0, 8'd40};
    bus.i_req_b     = {8'd0, 8'd2};
    bus.i_req_op    = {OP_ADD, OP_ADD};
    #1;
    check("abort_accept", {30'b0, bus.o_req_ready}, 32'h1);
    @(negedge clk);
    i_reset         = 1'b1;
    bus.i_req_valid = 2'b11;
    #1;
    check("abort_ready_in_rst", {30'b0, bus.o_req_ready}, 32'h0);
    check("abort_rsp_in_rst",   {30'b0, bus.o_rsp_valid}, 32'h0);
    @(negedge clk);
    i_reset         = 1'b0;
    bus.i_req_valid = 2'b00;
    #1;
    check_outputs_zero("abort");
    @(negedge clk);
    #1;
    check("abort_no_rsp",  {30'b0, bus.o_rsp_valid}, 32'h0);
    check("abort_no_busy", {31'b0, bus.o_busy}, 32'h0);
    m_last = 1;
    do_txn(2'b11, 8'd7, 8'd7, OP_ADD, 8'd9, 8'd9, OP_ADD, winner(2'b11),
           (winner(2'b11) == 1) ? 8'd18 : 8'd14, 0);

    // Four back-to-back ties.
    for (int k = 0; k < 4; k++) begin
      g = winner(2'b11);
      do_txn(2'b11, 8'(k), 8'd1, OP_ADD, 8'(k), 8'd2, OP_ADD, g,
             (g == 1) ? 8'(k + 2) : 8'(k + 1), 0);
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 40; k++) begin
      v   = 2'($urandom_range(1, 3));
      a0  = 8'($urandom);
      b0  = 8'($urandom);
      a1  = 8'($urandom);
      b1  = 8'($urandom);
      op0 = ops[$urandom_range(0, 4)];
      op1 = ops[$urandom_range(0, 4)];
      g   = winner(v);
      r   = (g == 1) ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
      do_txn(v, a0, b0, op0, a1, b1, op1, g, r, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
